// File: rtl/slave_spi.sv
// SPI slave: oversamples sclk/ss/mosi in the clk_s domain and exchanges one
// DATA_WIDTH word per ss-low frame, MSB first, in any CPOL/CPHA mode.
module slave_spi #(
  parameter int DATA_WIDTH = 8,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                  clk_s,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_in_slave,
  output logic [DATA_WIDTH-1:0] data_out_slave,
  output logic                  finish,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int              CW        = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0]   FULL      = CW'(DATA_WIDTH);
  localparam logic            IDLE_LVL  = (CPOL != 0);
  localparam bit              SAMPLE_ON_RISE = ((CPOL != 0) == (CPHA != 0));

  typedef enum logic [1:0] {IDLE, LOAD, EXE, DONE} state_t;

  state_t                state_q, state_d;
  logic                  sclkMeta_q, sclkSync_q, sclkPrev_q;
  logic                  ssMeta_q, ssSync_q;
  logic                  mosiMeta_q, mosiSync_q;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  finish_q, finish_d;
  logic                  err_q, err_d;
  logic                  sclkRise, sclkFall, sampleEdge, shiftEdge;

  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      sclkMeta_q <= IDLE_LVL;
      sclkSync_q <= IDLE_LVL;
      sclkPrev_q <= IDLE_LVL;
      ssMeta_q   <= 1'b1;
      ssSync_q   <= 1'b1;
      mosiMeta_q <= 1'b0;
      mosiSync_q <= 1'b0;
    end else begin
      sclkMeta_q <= sclk;
      sclkSync_q <= sclkMeta_q;
      sclkPrev_q <= sclkSync_q;
      ssMeta_q   <= ss;
      ssSync_q   <= ssMeta_q;
      mosiMeta_q <= mosi;
      mosiSync_q <= mosiMeta_q;
    end
  end

  assign sclkRise   = sclkSync_q & ~sclkPrev_q;
  assign sclkFall   = ~sclkSync_q & sclkPrev_q;
  assign sampleEdge = SAMPLE_ON_RISE ? sclkRise : sclkFall;
  assign shiftEdge  = SAMPLE_ON_RISE ? sclkFall : sclkRise;

  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      finish_q <= finish_d;
      err_q    <= err_d;
    end
  end

  // The frame registers are primed as LOAD is entered so miso already shows
  // the transmit MSB for the whole LOAD cycle.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    finish_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ssSync_q) begin
          state_d = LOAD;
          tx_d    = data_in_slave;
          rx_d    = '0;
          cnt_d   = '0;
        end
      end
      LOAD: state_d = EXE;
      EXE: begin
        if (cnt_q == FULL) begin
          state_d  = DONE;
          dout_d   = rx_q;
          finish_d = 1'b1;
        end else if (ssSync_q) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (sampleEdge) begin
          rx_d  = {rx_q[DATA_WIDTH-2:0], mosiSync_q};
          cnt_d = cnt_q + CW'(1);
        end else if (shiftEdge && cnt_q != '0) begin
          // A leading shift edge before any sample (CPHA=1) must keep the MSB.
          tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      DONE: begin
        if (ssSync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso           = (state_q != IDLE) & tx_q[DATA_WIDTH-1];
  assign busy           = (state_q != IDLE);
  assign finish         = finish_q;
  assign frame_err      = err_q;
  assign data_out_slave = dout_q;

endmodule

// File: doc/slave_spi.md
SLAVE_SPI -- requirements
Module: slave_spi

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per frame (>=2).
REQ-002 Parameter CPOL, default 0, sclk idle level.
REQ-003 Parameter CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 clk_s  input  1  block clock; one clock domain; rising-edge active.
REQ-005 rst_n  input  1  reset; asynchronous assertion; active-low.
REQ-006 sclk  input  1  SPI clock from master; asynchronous to clk_s.
REQ-007 ss  input  1  slave select; active low; asynchronous to clk_s.
REQ-008 mosi  input  1  serial data from master; MSB first.
REQ-009 miso  output  1  serial data to master; MSB first.
REQ-010 data_in_slave  input  DATA_WIDTH  word to transmit; captured at frame start.
REQ-011 data_out_slave  output  DATA_WIDTH  last complete received word.
REQ-012 finish  output  1  one-cycle pulse when a full word is received.
REQ-013 busy  output  1  high while a frame is in progress (states LOAD, EXE, DONE).
REQ-014 frame_err  output  1  one-cycle pulse when ss deasserts before DATA_WIDTH bits are sampled.

Function
REQ-015 sclk, ss and mosi SHALL each pass through a 2-flop synchronizer in clk_s; all logic uses the synchronized copies.
REQ-016 Edges of the synchronized sclk SHALL be detected with one additional register stage (rise = cur & ~prev, fall = ~cur & prev).
REQ-017 Sample edge SHALL be rise when CPOL^CPHA=0 and fall otherwise; shift edge SHALL be the opposite edge.
REQ-018 The FSM SHALL have four states: IDLE, LOAD, EXE, DONE.
REQ-019 IDLE->LOAD when synchronized ss is low; LOAD->EXE unconditionally after 1 cycle; EXE->DONE when the bit counter reaches DATA_WIDTH; DONE->IDLE when synchronized ss is high.
REQ-020 EXE->IDLE when synchronized ss is high before the count reaches DATA_WIDTH, with frame_err pulsed for 1 cycle.
REQ-021 In LOAD, the tx shift register SHALL load data_in_slave, and the rx shift register and the bit counter SHALL clear.
REQ-022 miso SHALL equal the tx shift register MSB in LOAD, EXE and DONE, and SHALL be 0 in IDLE.
REQ-023 On each sample edge in EXE, rx SHALL shift left with the synchronized mosi entering the LSB, and the counter SHALL increment.
REQ-024 On a shift edge in EXE, tx SHALL shift left with a 0 fill only if at least one sample edge has occurred in this frame; a shift edge before the first sample edge (CPHA=1 leading edge) SHALL be ignored.
REQ-025 On the cycle of the EXE->DONE transition, data_out_slave SHALL load the completed rx word and finish SHALL pulse high for exactly 1 cycle.
REQ-026 data_out_slave SHALL hold its value at all other times; an aborted frame SHALL NOT alter it.
REQ-027 sclk edges in DONE and IDLE SHALL be ignored; extra edges SHALL NOT change data_out_slave or produce a second finish.
REQ-028 The counter width SHALL be clog2(DATA_WIDTH)+1 bits; the counter SHALL never exceed DATA_WIDTH.
REQ-029 Latency: miso SHALL be valid within 4 clk_s cycles of ss falling; finish SHALL occur within 4 clk_s cycles of the last sample edge.
REQ-030 Operating constraint: each sclk half-period and the ss-low-to-first-edge time SHALL be >=4 clk_s cycles; behaviour is undefined otherwise.
REQ-031 Back-to-back frames: ss high for >=4 clk_s cycles between frames SHALL be sufficient to return to IDLE and start a new LOAD.

Reset
REQ-032 While rst_n is low: state IDLE; miso=0; data_out_slave=0; finish=0; busy=0; frame_err=0; all shift registers, counters and synchronizer flops = 0 except the sclk synchronizer, which resets to CPOL and the ss synchronizer, which resets to 1.
REQ-033 Reset asserted mid-frame SHALL abandon the frame without a finish or frame_err pulse; after release, the block SHALL wait in IDLE for the next synchronized ss low.

Verification
REQ-034 Mode 0, W=8: data_in_slave=0x3C, master sends 0xA5 -> data_out_slave=0xA5, master receives 0x3C (miso 0,0,1,1,1,1,0,0), one finish pulse.
REQ-035 Mode 3 (CPOL=1, CPHA=1): data_in_slave=0x81, master sends 0x5A -> data_out_slave=0x5A, master receives 0x81, one finish pulse.
REQ-036 Abort: mode 0, ss raised after 5 sample edges with prior data_out_slave=0xA5 -> frame_err pulses once, no finish, data_out_slave stays 0xA5, busy drops.
REQ-037 Back-to-back: frames 0x11 then 0xEE with the minimum ss gap -> two finish pulses, data_out_slave=0x11 then 0xEE; second frame's miso reflects the re-sampled data_in_slave.
REQ-038 Reset mid-frame after 3 bits -> all outputs 0 immediately; a following full frame 0xC3 completes normally with data_out_slave=0xC3.
REQ-039 Extra edges: 10 sclk cycles with ss low, W=8 -> exactly one finish; data_out_slave = first 8 bits.
